mem_port_arbiter: RTL and testbench

- Round-robin arbiter sharing one 32-bit datapath resource (memory/bus port fronted by a 4:1 select mux) among 4 requesters.
- Issues a registered one-hot grant and the matching 2-bit mux select.
- Holds ownership until the resource signals transaction completion.
- Sits between requesters (fetch, load/store, debug, DMA) and the shared-port mux select.

---
 rtl/mem_port_arbiter.sv | 174 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Purpose:
//   Round-robin arbiter that shares one 32-bit datapath resource among four
//   requesters: fetch, load/store, debug and DMA. The resource is a memory or
//   bus port behind a 4:1 select mux.
//   - A requester wins from IDLE and keeps ownership until the resource
//     reports arb_done.
//   - On release, the priority pointer moves to owner+1, so the previous
//     owner has the lowest priority.
//   - A pending request is granted on the release edge itself, with no idle
//     cycle between owners.
//
// Optional feature (macro ARB_TIMEOUT_EN):
//   Adds a per-grant watchdog. After TIMEOUT_CYCLES BUSY cycles without
//   arb_done, the grant is force-released and arb_timeout pulses for one
//   cycle. Without the macro there is no counter, the grant is held until
//   arb_done, and arb_timeout is tied low.
//
// Parameters:
//   TIMEOUT_CYCLES  maximum number of BUSY cycles without arb_done
//                   (ARB_TIMEOUT_EN only); legal range 2..255
//
// Ports:
//   clk          in   1  system clock, rising edge
//   rst          in   1  asynchronous, active-high reset
//   arb_req      in   4  level-sensitive request, bit i = requester i
//   arb_done     in   1  resource finished the current owner's transaction
//   arb_gnt      out  4  registered one-hot grant, zero when idle
//   arb_sel      out  2  registered index of the current/last owner (mux select)
//   arb_busy     out  1  registered, high while a grant is active (FSM state)
//   arb_timeout  out  1  registered one-cycle pulse on a forced release
//
// Handshake: a grant is valid from the edge after the request is seen. It
// stays valid, ignoring every change on arb_req, until an edge samples
// arb_done=1 (or the watchdog fires). arb_done is ignored while idle.
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] arb_req,
    input  logic       arb_done,
    output logic [3:0] arb_gnt,
    output logic [1:0] arb_sel,
    output logic       arb_busy,
    output logic       arb_timeout
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("mem_port_arbiter: TIMEOUT_CYCLES must be in 2..255");
    end

    logic [0:0] state_q, state_d;
    logic [1:0] ptr_q,   ptr_d;
    logic [3:0] gnt_q,   gnt_d;
    logic [1:0] sel_q,   sel_d;

    logic       force_rel;    // watchdog release this edge
    logic       release_now;  // owner gives up the port this edge
    logic       new_grant;    // a grant is issued this edge
    logic [1:0] base;         // first index in the priority scan
    logic       found;
    logic [1:0] win;

    always_comb begin
        release_now = (state_q == ST_BUSY) && (arb_done || force_rel);
    end

    // While BUSY, the only edge that can grant is a release edge. Scanning
    // from owner+1 on that edge is exactly the post-release pointer.
    always_comb begin
        base = (state_q == ST_BUSY) ? (sel_q + 2'd1) : ptr_q;
    end

    always_comb begin
        found = 1'b0;
        win   = base;
        for (int i = 0; i < 4; i++) begin
            if (!found && arb_req[base + 2'(i)]) begin
                found = 1'b1;
                win   = base + 2'(i);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        gnt_d     = gnt_q;
        sel_d     = sel_q;
        new_grant = 1'b0;
        if (state_q == ST_IDLE) begin
            if (found) begin
                gnt_d     = 4'b0001 << win;
                sel_d     = win;
                state_d   = ST_BUSY;
                new_grant = 1'b1;
            end
        end else if (release_now) begin
            ptr_d = base;
            if (found) begin
                gnt_d     = 4'b0001 << win;
                sel_d     = win;
                new_grant = 1'b1;
            end else begin
                // sel keeps the last owner so the mux output stays put
                gnt_d   = 4'b0000;
                state_d = ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= 2'd0;
            gnt_q   <= 4'b0000;
            sel_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    logic [7:0] cnt_q, cnt_d;
    logic       tmo_q, tmo_d;

    // cnt_q equals TIMEOUT_CYCLES-1 on the last allowed BUSY cycle
    always_comb begin
        force_rel = (state_q == ST_BUSY) && !arb_done
                    && (cnt_q == 8'(TIMEOUT_CYCLES - 1));
    end

    always_comb begin
        cnt_d = cnt_q;
        if (new_grant) begin
            cnt_d = 8'd0;
        end else if ((state_q == ST_BUSY) && !arb_done) begin
            cnt_d = cnt_q + 8'd1;
        end
        // done and timeout together count as a normal release
        tmo_d = force_rel;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= 8'd0;
            tmo_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tmo_q <= tmo_d;
        end
    end

    assign arb_timeout = tmo_q;
`else
    assign force_rel   = 1'b0;
    assign arb_timeout = 1'b0;
`endif

    assign arb_gnt  = gnt_q;
    assign arb_sel  = sel_q;
    assign arb_busy = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    localparam int TO = 8;

    logic       clk;
    logic       rst;
    logic [3:0] arb_req;
    logic       arb_done;
    logic [3:0] arb_gnt;
    logic [1:0] arb_sel;
    logic       arb_busy;
    logic       arb_timeout;

    // expected output word: {timeout, busy, sel[1:0], gnt[3:0]}
    logic [7:0] exp_q[$];
    string      name_q[$];

    int n_run  = 0;
    int n_fail = 0;

    mem_port_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .clk        (clk),
        .rst        (rst),
        .arb_req    (arb_req),
        .arb_done   (arb_done),
        .arb_gnt    (arb_gnt),
        .arb_sel    (arb_sel),
        .arb_busy   (arb_busy),
        .arb_timeout(arb_timeout)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    function automatic logic [7:0] ex(input logic [3:0] g, input logic [1:0] s,
                                      input logic b, input logic t);
        return {t, b, s, g};
    endfunction

    task automatic check(input string nm, input logic [7:0] act, input logic [7:0] expv);
        n_run++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got {to,busy,sel,gnt}=%b expected %b", nm, act, expv);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic push_exp(input string nm, input logic [7:0] expv);
        exp_q.push_back(expv);
        name_q.push_back(nm);
    endtask

    // drive inputs for the coming rising edge and queue the post-edge outputs
    task automatic step(input string nm, input logic [3:0] req, input logic done,
                        input logic [7:0] expv);
        @(negedge clk);
        arb_req  = req;
        arb_done = done;
        push_exp(nm, expv);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            @(posedge clk);
            #2;
            n++;
        end
        n_run++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
            exp_q.delete();
            name_q.delete();
        end
    endtask

    // assert reset between edges and check that outputs clear before the next edge
    task automatic async_reset(input string nm);
        @(posedge clk);
        #3;
        arb_req  = 4'b0000;
        arb_done = 1'b0;
        rst      = 1'b1;
        #1;
        check(nm, {arb_timeout, arb_busy, arb_sel, arb_gnt}, ex(4'b0000, 2'd0, 1'b0, 1'b0));
        @(negedge clk);
        rst = 1'b0;
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(posedge clk) begin
        logic [7:0] e;
        string      nm;
        #1;
        if (!rst && exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            check(nm, {arb_timeout, arb_busy, arb_sel, arb_gnt}, e);
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        rst      = 1'b1;
        arb_req  = 4'b1111;
        arb_done = 1'b0;

        // 1. reset holds outputs low even with all requests set
        repeat (2) @(posedge clk);
        #1;
        check("rst_hold", {arb_timeout, arb_busy, arb_sel, arb_gnt}, ex(4'b0000, 2'd0, 1'b0, 1'b0));
        @(negedge clk);
        rst = 1'b0;
        push_exp("rst_release", ex(4'b0001, 2'd0, 1'b1, 1'b0));

        // 3. round robin, back-to-back with done every BUSY cycle
        step("rr_1", 4'b1111, 1'b1, ex(4'b0010, 2'd1, 1'b1, 1'b0));
        step("rr_2", 4'b1111, 1'b1, ex(4'b0100, 2'd2, 1'b1, 1'b0));
        step("rr_3", 4'b1111, 1'b1, ex(4'b1000, 2'd3, 1'b1, 1'b0));
        step("rr_wrap", 4'b1111, 1'b1, ex(4'b0001, 2'd0, 1'b1, 1'b0));
        step("rr_to_idle", 4'b0000, 1'b1, ex(4'b0000, 2'd0, 1'b0, 1'b0));

        // 2. single request, then release to idle; sel keeps last owner
        step("single_gnt", 4'b0100, 1'b0, ex(4'b0100, 2'd2, 1'b1, 1'b0));
        step("single_rel", 4'b0000, 1'b1, ex(4'b0000, 2'd2, 1'b0, 1'b0));
        step("idle_done_ign", 4'b0000, 1'b1, ex(4'b0000, 2'd2, 1'b0, 1'b0));
        step("idle_hold", 4'b0000, 1'b0, ex(4'b0000, 2'd2, 1'b0, 1'b0));
        drain();

        // 4. hold while the owner drops its request, then back-to-back
        async_reset("rst_before_hold");
        step("hold_gnt", 4'b1010, 1'b0, ex(4'b0010, 2'd1, 1'b1, 1'b0));
        for (int i = 0; i < 5; i++)
            step("hold_stable", 4'b1000, 1'b0, ex(4'b0010, 2'd1, 1'b1, 1'b0));
        step("hold_b2b", 4'b1000, 1'b1, ex(4'b1000, 2'd3, 1'b1, 1'b0));
        drain();

        // 5. reset mid-grant clears outputs and the pointer
        async_reset("rst_mid_grant");
        step("ptr_reset", 4'b1001, 1'b0, ex(4'b0001, 2'd0, 1'b1, 1'b0));
        step("ptr_rel", 4'b0000, 1'b1, ex(4'b0000, 2'd0, 1'b0, 1'b0));
        drain();

        // 6. watchdog
        async_reset("rst_before_to");
        step("to_gnt", 4'b0011, 1'b0, ex(4'b0001, 2'd0, 1'b1, 1'b0));
`ifdef ARB_TIMEOUT_EN
        for (int i = 0; i < TO - 1; i++)
            step("to_hold", 4'b0011, 1'b0, ex(4'b0001, 2'd0, 1'b1, 1'b0));
        step("to_fire", 4'b0011, 1'b0, ex(4'b0010, 2'd1, 1'b1, 1'b1));
        for (int i = 0; i < TO - 1; i++)
            step("to_hold2", 4'b0011, 1'b0, ex(4'b0010, 2'd1, 1'b1, 1'b0));
        step("done_and_to", 4'b0011, 1'b1, ex(4'b0001, 2'd0, 1'b1, 1'b0));
`else
        for (int i = 0; i < TO + 3; i++)
            step("no_to_hold", 4'b0011, 1'b0, ex(4'b0001, 2'd0, 1'b1, 1'b0));
`endif
        step("to_end_idle", 4'b0000, 1'b1, ex(4'b0000, 2'd0, 1'b0, 1'b0));
        drain();

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
